branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch predictor for the pipelined RISC-V core: a tagged branch target buffer (BTB) plus a pattern history table (PHT) of saturating counters with optional gshare global history. The fetch stage presents the fetch PC and gets a registered prediction one cycle later, aligned with the decode stage like the synchronous instruction memories. The memory stage trains the predictor with resolved branch outcomes. Two 32-bit performance counters track resolved branches and mispredictions.

## Interface

- ENTRIES, 64, BTB and PHT depth; power of two, ≥4; IDX = log2(ENTRIES)
- TAG_BITS, 8, BTB tag width taken from the PC above the index bits
- CTR_BITS, 2, PHT counter width (2..4)
- GHR_BITS, 0, global history length; 0 = bimodal; must be ≤ IDX
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- bp_enable  input  1  gates predictions only; training continues when low
- if_stall  input  1  hold prediction outputs and ignore if_pc
- if_pc  input  32  fetch PC (word aligned)
- pred_hit  output  1  BTB tag hit for the PC registered last cycle
- pred_taken  output  1  predict taken
- pred_target  output  32  predicted target (valid when pred_taken)
- upd_valid  input  1  resolved conditional branch this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual target
- upd_mispredict  input  1  pipeline flushed for this branch
- clr_stats  input  1  synchronous clear of both perf counters
- stat_branches  output  32  resolved-branch count
- stat_mispredicts  output  32  misprediction count

## Operation

- Index: bidx = pc[IDX+1:2]; tag = pc[IDX+TAG_BITS+1:IDX+2]; pidx = bidx XOR {GHR zero-extended to IDX bits}.
- BTB entry: valid, tag, target[31:2]; target[1:0] is always 0.
- Lookup (cycle N, if_stall=0): read BTB[bidx(if_pc)] and PHT[pidx(if_pc)]; register at the edge ending cycle N:
  - pred_hit = valid & tag match
  - pred_taken = bp_enable & pred_hit & counter MSB
  - pred_target = stored target when pred_hit, else 0
- Update (upd_valid=1):
  - BTB hit: counter +1 if taken / −1 if not, saturating at 2^CTR_BITS−1 and 0; overwrite target if taken.
  - BTB miss, taken: allocate (valid=1, tag, target); PHT[pidx] := 2^(CTR_BITS−1) (weakly taken).
  - BTB miss, not taken: no change to BTB or PHT.
  - GHR (if GHR_BITS>0) := {GHR[GHR_BITS−2:0], upd_taken}; pidx for the update uses GHR before the shift.
  - stat_branches +1; stat_mispredicts +1 if upd_mispredict; both wrap at 2^32.
- clr_stats zeroes both counters and takes priority over a same-cycle increment.
- Tables are flop-based so they can be reset asynchronously.

## Timing

- Reset (rst_n low, asynchronous): all BTB valid=0; all PHT counters := 2^(CTR_BITS−1)−1 (weakly not-taken); GHR=0; pred_hit=0, pred_taken=0, pred_target=0; stats=0. Release is synchronised by the caller; the first edge after release may perform a lookup.
- Lookup latency: 1 cycle, if_pc to outputs.
- if_stall=1: outputs hold their values; no lookup. An update in the same cycle still commits.
- Same-cycle lookup and update to the same bidx/pidx: the lookup sees pre-update state; no bypass.
- Update side effects are visible to lookups presented on the next cycle.
- bp_enable is combinational into the output register: toggling it affects the prediction registered at the next edge, not the current outputs.
- Aliasing: different PCs with an identical index and tag share an entry, which is acceptable. A tag mismatch on a taken update replaces the entry.

## Test plan

- Reset, then lookup 0x4000_0000 -> pred_hit=0, pred_taken=0, pred_target=0; stats=0.
- Update pc=0x100, taken, target=0x80 (CTR_BITS=2) -> next-cycle lookup 0x100 gives pred_hit=1, pred_taken=1, pred_target=0x80. Two not-taken updates -> pred_taken=0 with pred_hit=1. Four taken updates -> counter saturates at 3; one not-taken still predicts taken.
- Aliasing with ENTRIES=64, TAG_BITS=8: train 0x100 taken, then update 0x4100 (same index, different tag) taken to 0x200 -> lookup 0x100 gives pred_hit=0; lookup 0x4100 gives target 0x200.
- Hold behaviour with a trained entry: bp_enable=0 -> pred_taken=0 and pred_hit=1. if_stall held for 3 cycles while if_pc changes -> outputs constant.
- Gshare with GHR_BITS=4: the same pc alternates taken/not-taken 20 times -> after warm-up, predictions match the outcome every time; with GHR_BITS=0 they do not. Assert rst_n mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
- Perf counters: 10 updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. clr_stats together with an update -> both 0. Preload near 0xFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Tagged BTB plus PHT of saturating counters (bimodal or gshare), registered one-cycle
// prediction for fetch, training from resolved branches, and two 32-bit perf counters.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_enable,
  input  logic        if_stall,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        clr_stats,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic                pred_hit_q, pred_hit_d;
  logic                pred_taken_q, pred_taken_d;
  logic [31:0]         pred_target_q, pred_target_d;
  logic [31:0]         stat_br_q, stat_mis_q;

  logic [IDX-1:0]      ghr_idx_s;
  logic [IDX-1:0]      l_bidx_s, l_pidx_s, u_bidx_s, u_pidx_s;
  logic [TAG_BITS-1:0] l_tag_s, u_tag_s;
  logic                l_hit_s, u_hit_s;
  logic [CTR_BITS-1:0] l_ctr_s, u_ctr_s, u_ctr_next_s;
  logic                unused_s;

  // PC bits outside index/tag and the byte offset carry no information here
  assign unused_s = ^{if_pc, upd_pc, upd_target};

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr_q;
      // Global history shifts in each resolved outcome
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_q <= {GHR_BITS{1'b0}};
        end else if (upd_valid) begin
          ghr_q <= GHR_BITS'({ghr_q, upd_taken});
        end else begin
          ghr_q <= ghr_q;
        end
      end
      assign ghr_idx_s = IDX'(ghr_q);
    end else begin : g_bimodal
      assign ghr_idx_s = {IDX{1'b0}};
    end
  endgenerate

  assign l_bidx_s = if_pc[IDX+1:2];
  assign l_tag_s  = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign l_pidx_s = l_bidx_s ^ ghr_idx_s;
  assign l_hit_s  = valid_q[l_bidx_s] && (tag_q[l_bidx_s] == l_tag_s);
  assign l_ctr_s  = ctr_q[l_pidx_s];

  assign u_bidx_s = upd_pc[IDX+1:2];
  assign u_tag_s  = upd_pc[IDX+TAG_BITS+1:IDX+2];
  assign u_pidx_s = u_bidx_s ^ ghr_idx_s;
  assign u_hit_s  = valid_q[u_bidx_s] && (tag_q[u_bidx_s] == u_tag_s);
  assign u_ctr_s  = ctr_q[u_pidx_s];

  // Saturating counter step for a training update
  always_comb begin
    u_ctr_next_s = u_ctr_s;
    if (upd_taken) begin
      u_ctr_next_s = (u_ctr_s == CTR_MAX) ? u_ctr_s : u_ctr_s + CTR_ONE;
    end else begin
      u_ctr_next_s = (u_ctr_s == CTR_MIN) ? u_ctr_s : u_ctr_s - CTR_ONE;
    end
  end

  // Next prediction; a stalled fetch keeps the previous one
  always_comb begin
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (!if_stall) begin
      pred_hit_d    = l_hit_s;
      pred_taken_d  = bp_enable & l_hit_s & l_ctr_s[CTR_BITS-1];
      pred_target_d = l_hit_s ? {tgt_q[l_bidx_s], 2'b00} : 32'h0000_0000;
    end else begin
      pred_hit_d    = pred_hit_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
    end
  end

  // Prediction output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'h0000_0000;
    end else begin
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // BTB and PHT training; lookups this cycle still see the old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= {TAG_BITS{1'b0}};
        tgt_q[i] <= 30'h0000_0000;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (u_hit_s) begin
        ctr_q[u_pidx_s] <= u_ctr_next_s;
        if (upd_taken) begin
          tgt_q[u_bidx_s] <= upd_target[31:2];
        end else begin
          tgt_q[u_bidx_s] <= tgt_q[u_bidx_s];
        end
      end else if (upd_taken) begin
        valid_q[u_bidx_s] <= 1'b1;
        tag_q[u_bidx_s]   <= u_tag_s;
        tgt_q[u_bidx_s]   <= upd_target[31:2];
        ctr_q[u_pidx_s]   <= CTR_WT;
      end else begin
        valid_q <= valid_q;
      end
    end else begin
      valid_q <= valid_q;
    end
  end

  // Perf counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= 32'h0000_0000;
      stat_mis_q <= 32'h0000_0000;
    end else if (clr_stats) begin
      stat_br_q  <= 32'h0000_0000;
      stat_mis_q <= 32'h0000_0000;
    end else if (upd_valid) begin
      stat_br_q  <= stat_br_q + 32'd1;
      stat_mis_q <= upd_mispredict ? stat_mis_q + 32'd1 : stat_mis_q;
    end else begin
      stat_br_q  <= stat_br_q;
      stat_mis_q <= stat_mis_q;
    end
  end

  assign pred_hit         = pred_hit_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare predictor share stimulus; expected predictions
// are queued when a lookup is driven and compared when the registered output appears.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n, bp_enable, if_stall;
  logic [31:0] if_pc;
  logic        upd_valid, upd_taken, upd_mispredict, clr_stats;
  logic [31:0] upd_pc, upd_target;
  logic        bi_hit, bi_taken, gs_hit, gs_taken;
  logic [31:0] bi_tgt, gs_tgt, bi_sb, bi_sm, gs_sb, gs_sm;

  typedef struct {
    string       tag;
    bit          gs;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor dut_bi (
    .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable), .if_stall(if_stall), .if_pc(if_pc),
    .pred_hit(bi_hit), .pred_taken(bi_taken), .pred_target(bi_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clr_stats(clr_stats),
    .stat_branches(bi_sb), .stat_mispredicts(bi_sm)
  );

  branch_predictor #(.GHR_BITS(4)) dut_gs (
    .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable), .if_stall(if_stall), .if_pc(if_pc),
    .pred_hit(gs_hit), .pred_taken(gs_taken), .pred_target(gs_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clr_stats(clr_stats),
    .stat_branches(gs_sb), .stat_mispredicts(gs_sm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.gs) begin
        chk({e.tag, ".gs_hit"},   {31'd0, gs_hit},   {31'd0, e.hit});
        chk({e.tag, ".gs_taken"}, {31'd0, gs_taken}, {31'd0, e.taken});
        chk({e.tag, ".gs_tgt"},   gs_tgt,            e.tgt);
      end else begin
        chk({e.tag, ".hit"},   {31'd0, bi_hit},   {31'd0, e.hit});
        chk({e.tag, ".taken"}, {31'd0, bi_taken}, {31'd0, e.taken});
        chk({e.tag, ".tgt"},   bi_tgt,            e.tgt);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push(input string tag, input bit gs, input logic h, input logic t,
                      input logic [31:0] tg);
    exp_t e;
    e.tag = tag; e.gs = gs; e.hit = h; e.taken = t; e.tgt = tg;
    sb_q.push_back(e);
  endtask

  task automatic look_bi(input string tag, input logic [31:0] pc, input logic h,
                         input logic t, input logic [31:0] tg);
    if_pc = pc;
    push(tag, 1'b0, h, t, tg);
    step();
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg; upd_mispredict = mis;
    step();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    logic outcome;
    rst_n = 1'b0; bp_enable = 1'b1; if_stall = 1'b0; if_pc = 32'h0000_0000;
    upd_valid = 1'b0; upd_pc = 32'h0000_0000; upd_taken = 1'b0; upd_target = 32'h0000_0000;
    upd_mispredict = 1'b0; clr_stats = 1'b0;
    #12;
    chk("rst.hit", {31'd0, bi_hit}, 32'd0);
    chk("rst.taken", {31'd0, bi_taken}, 32'd0);
    chk("rst.tgt", bi_tgt, 32'd0);
    chk("rst.branches", bi_sb, 32'd0);
    chk("rst.mispredicts", bi_sm, 32'd0);
    rst_n = 1'b1;

    look_bi("cold", 32'h4000_0000, 1'b0, 1'b0, 32'h0000_0000);

    // allocate weakly taken, then walk the 2-bit counter
    upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    look_bi("alloc", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0080);
    upd(32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0);
    upd(32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0);
    look_bi("two_nt", 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0080);
    for (int i = 0; i < 4; i++) upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    look_bi("four_t", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0080);
    upd(32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0);
    look_bi("sat_hyst", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0080);

    // same index, different tag replaces the entry
    upd(32'h0000_4100, 1'b1, 32'h0000_0200, 1'b0);
    look_bi("alias_old", 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000);
    look_bi("alias_new", 32'h0000_4100, 1'b1, 1'b1, 32'h0000_0200);

    bp_enable = 1'b0;
    look_bi("bp_off", 32'h0000_4100, 1'b1, 1'b0, 32'h0000_0200);
    bp_enable = 1'b1;
    look_bi("bp_on", 32'h0000_4100, 1'b1, 1'b1, 32'h0000_0200);
    if_stall = 1'b1;
    look_bi("stall0", 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0200);
    look_bi("stall1", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200);
    look_bi("stall2", 32'h4000_0000, 1'b1, 1'b1, 32'h0000_0200);
    if_stall = 1'b0;

    // same-cycle lookup and update: no bypass
    if_pc = 32'h0000_0304;
    push("no_bypass", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    upd(32'h0000_0304, 1'b1, 32'h0000_0040, 1'b0);
    look_bi("after_upd", 32'h0000_0304, 1'b1, 1'b1, 32'h0000_0040);

    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr.branches", bi_sb, 32'd0);
    chk("clr.mispredicts", bi_sm, 32'd0);
    for (int i = 0; i < 10; i++) upd(32'h0000_0500 + 32'(4 * i), i[0], 32'h0000_0800, (i < 3));
    chk("ten.branches", bi_sb, 32'd10);
    chk("ten.mispredicts", bi_sm, 32'd3);
    clr_stats = 1'b1;
    upd(32'h0000_0500, 1'b1, 32'h0000_0800, 1'b1);
    clr_stats = 1'b0;
    chk("clr_upd.branches", bi_sb, 32'd0);
    chk("clr_upd.mispredicts", bi_sm, 32'd0);
    force dut_bi.stat_br_q  = 32'hFFFF_FFFF;
    force dut_bi.stat_mis_q = 32'hFFFF_FFFF;
    #1;
    release dut_bi.stat_br_q;
    release dut_bi.stat_mis_q;
    upd(32'h0000_0500, 1'b1, 32'h0000_0800, 1'b1);
    chk("wrap.branches", bi_sb, 32'd0);
    chk("wrap.mispredicts", bi_sm, 32'd0);

    // alternating branch: gshare learns it, bimodal predicts the previous outcome
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      outcome = (i % 2 == 0);
      if_pc = 32'h0000_0600;
      if (i >= 5) begin
        push($sformatf("alt%0d", i), 1'b1, 1'b1, outcome, 32'h0000_0700);
        push($sformatf("alt%0d", i), 1'b0, 1'b1, ~outcome, 32'h0000_0700);
      end
      step();
      upd(32'h0000_0600, outcome, 32'h0000_0700, 1'b0);
    end

    // asynchronous reset takes effect without a clock edge
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.hit", {31'd0, bi_hit}, 32'd0);
    chk("async.taken", {31'd0, bi_taken}, 32'd0);
    chk("async.tgt", bi_tgt, 32'd0);
    chk("async.gs_hit", {31'd0, gs_hit}, 32'd0);
    chk("async.gs_tgt", gs_tgt, 32'd0);
    chk("async.branches", gs_sb, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
